// File: rtl/max7219_tx_pkg.sv
// Shared types and constants for the MAX7219 serial transmitter.
package max7219_tx_pkg;

  // Transmitter FSM states.
  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StClkLow    = 2'd1,
    StClkHigh   = 2'd2,
    StLoadPulse = 2'd3
  } tx_state_e;

  // MAX7219 register addresses.
  localparam logic [3:0] AddrNoOp        = 4'h0;
  localparam logic [3:0] AddrDigit0      = 4'h1;
  localparam logic [3:0] AddrDigit1      = 4'h2;
  localparam logic [3:0] AddrDigit2      = 4'h3;
  localparam logic [3:0] AddrDigit3      = 4'h4;
  localparam logic [3:0] AddrDigit4      = 4'h5;
  localparam logic [3:0] AddrDigit5      = 4'h6;
  localparam logic [3:0] AddrDigit6      = 4'h7;
  localparam logic [3:0] AddrDigit7      = 4'h8;
  localparam logic [3:0] AddrDecodeMode  = 4'h9;
  localparam logic [3:0] AddrIntensity   = 4'hA;
  localparam logic [3:0] AddrScanLimit   = 4'hB;
  localparam logic [3:0] AddrShutdown    = 4'hC;
  localparam logic [3:0] AddrDisplayTest = 4'hF;

  // One device command frame: upper nibble is don't-care and sent as zero.
  function automatic logic [15:0] build_frame(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

endpackage

// File: rtl/max7219_tx_tick.sv
// Half-period timebase: one-cycle tick every G_CLK_DIV enabled cycles.
module max7219_tx_tick #(
  parameter int unsigned G_CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (G_CLK_DIV > 1) ? $clog2(G_CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(G_CLK_DIV - 1);

  logic [CntW-1:0] r_cnt;

  assign o_tick = i_en && (r_cnt == CntLast);

  // Count enabled cycles; restart on clear so the first half period is full length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear || o_tick) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/max7219_serial_tx.sv
// Serial transmitter for a chain of cascaded MAX7219 devices: shifts 16 bits per device
// MSB first on o_max7219_clk/o_max7219_din, then strobes o_max7219_load.
module max7219_serial_tx
  import max7219_tx_pkg::*;
#(
  parameter int unsigned G_MATRIX_N  = 1,
  parameter int unsigned G_CLK_DIV   = 4,
  parameter int unsigned G_LOAD_HOLD = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_start,
  input  logic [16*G_MATRIX_N-1:0]  i_frame_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_max7219_clk,
  output logic                      o_max7219_din,
  output logic                      o_max7219_load
);

  localparam int unsigned FrameW   = 16 * G_MATRIX_N;
  localparam int unsigned BitCntW  = $clog2(FrameW + 1);
  localparam int unsigned HoldCntW = (G_LOAD_HOLD > 1) ? $clog2(G_LOAD_HOLD) : 1;
  localparam logic [BitCntW-1:0]  BitCntInit = BitCntW'(FrameW);
  localparam logic [HoldCntW-1:0] HoldLast   = HoldCntW'(G_LOAD_HOLD - 1);

  tx_state_e r_state;
  tx_state_e w_state_d;

  // Bits still to be sent after the one currently on din (MSB is next out).
  logic [FrameW-2:0]   r_shift;
  logic [BitCntW-1:0]  r_bit_cnt;
  logic [HoldCntW-1:0] r_hold_cnt;

  logic r_clk;
  logic r_din;
  logic r_load;
  logic r_busy;
  logic r_done;

  logic w_clk_d;
  logic w_din_d;
  logic w_load_d;
  logic w_busy_d;
  logic w_done_d;

  logic w_accept;
  logic w_tick;
  logic w_tick_en;
  logic w_last_bit;
  logic w_bit_end;
  logic w_shift_en;
  logic w_hold_end;

  // A start coinciding with the done pulse is dropped; it is taken again next cycle.
  assign w_accept   = (r_state == StIdle) && i_start && !r_done;
  assign w_tick_en  = (r_state == StClkLow) || (r_state == StClkHigh);
  assign w_last_bit = (r_bit_cnt == BitCntW'(1));
  assign w_bit_end  = (r_state == StClkHigh) && w_tick;
  assign w_shift_en = w_bit_end && !w_last_bit;
  assign w_hold_end = (r_state == StLoadPulse) && (r_hold_cnt == HoldLast);

  max7219_tx_tick #(
    .G_CLK_DIV (G_CLK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_accept),
    .i_en    (w_tick_en),
    .o_tick  (w_tick)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state logic: two half periods per bit, then the load strobe.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_d = StClkLow;
        end
      end
      StClkLow: begin
        if (w_tick) begin
          w_state_d = StClkHigh;
        end
      end
      StClkHigh: begin
        if (w_tick) begin
          w_state_d = w_last_bit ? StLoadPulse : StClkLow;
        end
      end
      StLoadPulse: begin
        if (w_hold_end) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // FSM output logic: next values of the registered line outputs.
  always_comb begin
    w_clk_d  = (w_state_d == StClkHigh);
    w_load_d = (w_state_d == StLoadPulse);
    w_busy_d = (w_state_d != StIdle);
    w_done_d = w_hold_end;
    // din moves only when clk falls, giving a full half period of setup before each rise.
    w_din_d  = r_din;
    if (w_accept) begin
      w_din_d = i_frame_data[FrameW-1];
    end else if (w_shift_en) begin
      w_din_d = r_shift[FrameW-2];
    end else if ((w_state_d == StIdle) || (w_state_d == StLoadPulse)) begin
      w_din_d = 1'b0;
    end
  end

  // Registered serial-line and handshake outputs, glitch-free toward the devices.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk  <= 1'b0;
      r_din  <= 1'b0;
      r_load <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_clk  <= w_clk_d;
      r_din  <= w_din_d;
      r_load <= w_load_d;
      r_busy <= w_busy_d;
      r_done <= w_done_d;
    end
  end

  // Shift register and bit counter; frame is captured once so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_shift   <= i_frame_data[FrameW-2:0];
      r_bit_cnt <= BitCntInit;
    end else if (w_bit_end) begin
      if (r_bit_cnt != '0) begin
        r_bit_cnt <= r_bit_cnt - 1'b1;
      end
      if (!w_last_bit) begin
        r_shift <= {r_shift[FrameW-3:0], 1'b0};
      end
    end
  end

  // Load-hold counter runs only while the strobe is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state != StLoadPulse) begin
      r_hold_cnt <= '0;
    end else if (!w_hold_end) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_max7219_clk  = r_clk;
  assign o_max7219_din  = r_din;
  assign o_max7219_load = r_load;

endmodule

// File: tb/tb_max7219_serial_tx.sv
// Bench for max7219_serial_tx: a single-device and a two-device transmitter, each checked
// cycle by cycle against a timing model and feeding a behavioural MAX7219 chain model.
module tb_max7219_serial_tx;

  localparam int ClkDiv   = 4;
  localparam int LoadHold = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;

  logic        start0, start1;
  logic [15:0] frame0;
  logic [31:0] frame1;
  logic busy0, done0, mclk0, din0, load0;
  logic busy1, done1, mclk1, din1, load1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  max7219_serial_tx #(
    .G_MATRIX_N (1),
    .G_CLK_DIV  (ClkDiv),
    .G_LOAD_HOLD(LoadHold)
  ) u_dut0 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start0),
    .i_frame_data  (frame0),
    .o_busy        (busy0),
    .o_done        (done0),
    .o_max7219_clk (mclk0),
    .o_max7219_din (din0),
    .o_max7219_load(load0)
  );

  max7219_serial_tx #(
    .G_MATRIX_N (2),
    .G_CLK_DIV  (ClkDiv),
    .G_LOAD_HOLD(LoadHold)
  ) u_dut1 (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start1),
    .i_frame_data  (frame1),
    .o_busy        (busy1),
    .o_done        (done1),
    .o_max7219_clk (mclk1),
    .o_max7219_din (din1),
    .o_max7219_load(load1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- MAX7219 chain receiver model ----------------
  // Each rising clk shifts din into the chain; device 0 is nearest the transmitter.
  logic [31:0] rx_sr0, rx_sr1;
  logic [7:0]  regs0 [16];
  logic [7:0]  regs1_d0 [16];
  logic [7:0]  regs1_d1 [16];
  int rises0 = 0, rises1 = 0, frames0 = 0, frames1 = 0;

  always @(posedge mclk0) begin
    rx_sr0 = {rx_sr0[30:0], din0};
    rises0++;
  end
  always @(posedge mclk1) begin
    rx_sr1 = {rx_sr1[30:0], din1};
    rises1++;
  end
  always @(posedge load0) begin
    regs0[rx_sr0[11:8]] = rx_sr0[7:0];
    frames0++;
  end
  always @(posedge load1) begin
    regs1_d0[rx_sr1[11:8]]  = rx_sr1[7:0];
    regs1_d1[rx_sr1[27:24]] = rx_sr1[23:16];
    frames1++;
  end

  // ---------------- Transfer timing model ----------------
  // Expected {busy,done,clk,din,load} at cycle t after the accepting edge (t=1 is the first).
  function automatic logic [4:0] model_out(input int t, input logic [31:0] f, input int n);
    int total;
    int b;
    int ph;
    logic [4:0] r;
    total = 2 * ClkDiv * 16 * n;
    r = '0;
    if (t >= 1 && t <= total) begin
      b    = (t - 1) / (2 * ClkDiv);
      ph   = (t - 1) % (2 * ClkDiv);
      r[4] = 1'b1;
      r[2] = (ph >= ClkDiv);
      r[1] = f[16*n-1-b];
    end else if (t > total && t <= total + LoadHold) begin
      r[4] = 1'b1;
      r[0] = 1'b1;
    end else if (t == total + LoadHold + 1) begin
      r[3] = 1'b1;
    end
    return r;
  endfunction

  logic        m_active [2] = '{1'b0, 1'b0};
  logic        m_can    [2] = '{1'b1, 1'b1};
  int          m_s      [2] = '{0, 0};
  logic [31:0] m_frame  [2] = '{32'h0, 32'h0};
  int          done_cnt [2] = '{0, 0};
  int          stable   [2] = '{0, 0};
  logic        prev_din [2] = '{1'b0, 1'b0};
  logic        prev_clk [2] = '{1'b0, 1'b0};
  logic [4:0]  act_v, exp_v;
  logic        st_v;
  logic [31:0] fr_v;
  int          t_v;

  // Compare process: every cycle, both DUTs against the model plus line-protocol rules.
  always begin
    @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      if (u == 0) begin
        act_v = {busy0, done0, mclk0, din0, load0};
        st_v  = start0;
        fr_v  = {16'h0, frame0};
      end else begin
        act_v = {busy1, done1, mclk1, din1, load1};
        st_v  = start1;
        fr_v  = frame1;
      end
      if (rst_n && m_can[u] && st_v) begin
        m_active[u] = 1'b1;
        m_s[u]      = cyc - 1;
        m_frame[u]  = fr_v;
      end
      if (!rst_n) m_active[u] = 1'b0;
      t_v   = cyc - m_s[u];
      exp_v = m_active[u] ? model_out(t_v, m_frame[u], u + 1) : 5'b0;
      check($sformatf("u%0d.outs{busy,done,clk,din,load}", u), 32'(act_v), 32'(exp_v));
      if (act_v[3]) done_cnt[u]++;
      if (act_v[0]) check($sformatf("u%0d.load_lines_low", u), 32'(act_v[2:1]), 32'd0);
      if (!act_v[4]) check($sformatf("u%0d.load_without_busy", u), 32'(act_v[0]), 32'd0);
      if (act_v[1] != prev_din[u]) stable[u] = 1;
      else stable[u]++;
      if (act_v[2] && !prev_clk[u])
        check($sformatf("u%0d.din_setup_ok", u), 32'(stable[u] > ClkDiv), 32'd1);
      prev_din[u] = act_v[1];
      prev_clk[u] = act_v[2];
      if (m_active[u] && t_v == 2 * ClkDiv * 16 * (u + 1) + LoadHold + 1) begin
        m_active[u] = 1'b0;
        m_can[u]    = 1'b0;
      end else begin
        m_can[u] = !m_active[u];
      end
    end
  end

  // ---------------- Driver ----------------
  // Called at a negedge; returns at the negedge after the done cycle.
  task automatic send(input int u, input logic [31:0] f, output int lat);
    int cs;
    if (u == 0) begin start0 = 1'b1; frame0 = f[15:0]; end
    else begin start1 = 1'b1; frame1 = f; end
    cs = cyc;
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
    lat = -1;
    for (int i = 0; i < 3000; i++) begin
      if ((u == 0) ? done0 : done1) begin
        lat = cyc - cs;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base_f;
    int base_d;
    int base_r;
    start0 = 1'b0;
    start1 = 1'b0;
    frame0 = '0;
    frame1 = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset.u0_outs", 32'({busy0, done0, mclk0, din0, load0}), 32'd0);
    check("reset.u1_outs", 32'({busy1, done1, mclk1, din1, load1}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("pkg.build_frame",
          32'(max7219_tx_pkg::build_frame(max7219_tx_pkg::AddrShutdown, 8'h01)), 32'h0C01);

    // Single shutdown frame: register, one load, one done, latency.
    base_f = frames0;
    base_d = done_cnt[0];
    send(0, 32'h0C01, lat);
    check("t1.latency", 32'(lat), 32'd131);
    check("t1.frames", 32'(frames0 - base_f), 32'd1);
    check("t1.done_pulses", 32'(done_cnt[0] - base_d), 32'd1);
    check("t1.shutdown", 32'(regs0[4'hC]), 32'h01);

    // Back-to-back frames.
    base_f = frames0;
    send(0, 32'h0A05, lat);
    send(0, 32'h0B07, lat);
    send(0, 32'h0103, lat);
    check("t2.frames", 32'(frames0 - base_f), 32'd3);
    check("t2.intensity", 32'(regs0[4'hA]), 32'h05);
    check("t2.scan_limit", 32'(regs0[4'hB]), 32'h07);
    check("t2.digit0", 32'(regs0[4'h1]), 32'h03);

    // Two cascaded devices: MSB frame lands in the far device.
    base_r = rises1;
    send(1, 32'h0A05_0103, lat);
    check("t3.latency", 32'(lat), 32'd259);
    check("t3.clk_rises", 32'(rises1 - base_r), 32'd32);
    check("t3.dev0_digit0", 32'(regs1_d0[4'h1]), 32'h03);
    check("t3.dev1_intensity", 32'(regs1_d1[4'hA]), 32'h05);

    // Start held high and data scrambled during a transfer, including the done cycle.
    base_f = frames0;
    base_d = done_cnt[0];
    start0 = 1'b1;
    frame0 = 16'h0F01;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      frame0 = 16'($urandom);
      if (done0) break;
      check("t4.busy_held", 32'(busy0), 32'd1);
    end
    @(negedge clk);
    start0 = 1'b0;
    repeat (10) @(negedge clk);
    check("t4.no_restart", 32'(busy0), 32'd0);
    check("t4.frames", 32'(frames0 - base_f), 32'd1);
    check("t4.done_pulses", 32'(done_cnt[0] - base_d), 32'd1);
    check("t4.display_test", 32'(regs0[4'hF]), 32'h01);

    // Asynchronous reset in the middle of a frame, then a clean resend.
    base_r = rises0;
    start0 = 1'b1;
    frame0 = 16'h01AA;
    @(negedge clk);
    start0 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (rises0 - base_r >= 7) break;
      @(negedge clk);
    end
    check("t5.reached_bit7", 32'(rises0 - base_r), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    check("t5.reset_outs", 32'({busy0, done0, mclk0, din0, load0}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base_r = rises0;
    send(0, 32'h0155, lat);
    check("t5.latency", 32'(lat), 32'd131);
    check("t5.clk_rises", 32'(rises0 - base_r), 32'd16);
    check("t5.digit0", 32'(regs0[4'h1]), 32'h55);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
